// File: rtl/mux_pkg.sv
// mux_pkg: mode encodings shared by the stream multiplexer.
package mux_pkg;
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;
endpackage

// File: rtl/rr_stream_mux_rr_pick.sv
// rr_pick: combinational rotating-priority picker; the first request at or after ptr wins.
module rr_pick #(
    parameter int NUM_CH = 4,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic              gnt_vld,
    output logic [SEL_W-1:0]  gnt_idx
);
    logic [SEL_W-1:0] w_idx;

    // Scan from the farthest offset down so the nearest request is written last.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        w_idx   = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            w_idx = SEL_W'((int'(ptr) + k) % NUM_CH);
            if (req[w_idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = w_idx;
            end
        end
    end
endmodule

// File: rtl/rr_stream_mux.sv
// rr_stream_mux: N:1 valid/ready stream mux, fixed or round-robin select, one registered output slot.
module rr_stream_mux
    import mux_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic [NUM_CH-1:0]        in_ready,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_ch,
    input  logic                     out_ready
);
    localparam int PAD = 1 << SEL_W;

    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [SEL_W-1:0]  r_out_ch;
    logic [SEL_W-1:0]  r_rr_ptr;
    logic              w_load_en;
    logic              w_pick_vld;
    logic [SEL_W-1:0]  w_pick_idx;
    logic [PAD-1:0]    w_vpad;
    logic              w_gnt_vld;
    logic [SEL_W-1:0]  w_gnt;
    logic              w_xfer;
    logic [SEL_W-1:0]  w_nxt_ptr;

    rr_pick #(.NUM_CH(NUM_CH), .SEL_W(SEL_W)) u_pick (
        .req     (in_valid),
        .ptr     (r_rr_ptr),
        .gnt_vld (w_pick_vld),
        .gnt_idx (w_pick_idx)
    );

    // Zero-padding the valid vector makes out-of-range sel values read as "not valid".
    assign w_vpad    = PAD'(in_valid);
    assign w_load_en = !r_out_valid || out_ready;
    assign w_gnt_vld = (mode == MODE_RR) ? w_pick_vld : w_vpad[sel];
    assign w_gnt     = (mode == MODE_RR) ? w_pick_idx : sel;
    assign w_xfer    = rst_n && w_load_en && w_gnt_vld;
    assign in_ready  = w_xfer ? (NUM_CH'(1) << w_gnt) : '0;
    assign w_nxt_ptr = (w_gnt == SEL_W'(NUM_CH - 1)) ? '0 : w_gnt + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_rr_ptr    <= '0;
        end else if (w_load_en) begin
            r_out_valid <= w_gnt_vld;
            if (w_gnt_vld) begin
                r_out_data <= in_data[w_gnt*DATA_W +: DATA_W];
                r_out_ch   <= w_gnt;
                if (mode == MODE_RR)
                    r_rr_ptr <= w_nxt_ptr;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;
endmodule
